recovery_sequencer: RTL and testbench
=====================================

RECOVERY_SEQUENCER -- requirements
Module: recovery_sequencer

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 The module SHALL have these parameters (name, default, meaning):
- ADDR_WIDTH, 5: register-file address width.
- DATA_WIDTH, 32: register data width.
- CNT_WIDTH, 8: error-event counter width.
REQ-003 The module SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- error_i, in, 1: lockstep mismatch, sampled each cycle.
- core_we_i, in, 1: normal core register write enable.
- core_waddr_i, in, ADDR_WIDTH: normal core write address.
- core_wdata_i, in, DATA_WIDTH: normal core write data.
- ckpt_raddr_o, out, ADDR_WIDTH: checkpoint bank read address.
- ckpt_rdata_i, in, DATA_WIDTH: checkpoint read data, valid 1 cycle after address.
- ckpt_pc_i, in, 32: checkpointed program counter.
- rf_we_o, out, 1: register-file write enable.
- rf_waddr_o, out, ADDR_WIDTH: register-file write address.
- rf_wdata_o, out, DATA_WIDTH: register-file write data.
- halt_o, out, 1: core fetch stall.
- pc_restore_o, out, 1: one-cycle PC reload strobe.
- pc_o, out, 32: PC to reload.
- busy_o, out, 1: recovery in progress.
- err_count_o, out, CNT_WIDTH: accepted error events, saturating.

Function
REQ-004 The module SHALL implement the states IDLE, COPY, FLUSH and RESTORE; NUM_REG SHALL equal 2**ADDR_WIDTH.
REQ-005 In IDLE, rf_we_o/rf_waddr_o/rf_wdata_o SHALL equal core_we_i/core_waddr_i/core_wdata_i combinationally, with halt_o=0 and busy_o=0.
REQ-006 In IDLE, error_i=1 at edge t SHALL move the FSM to COPY at t+1, clear the address counter to 0 and increment err_count_o.
REQ-007 In COPY, ckpt_raddr_o SHALL equal the counter, which increments by 1 each cycle.
REQ-008 In COPY, rf_we_o SHALL be 1 in every cycle except the first, with rf_waddr_o = counter-1 and rf_wdata_o = ckpt_rdata_i.
REQ-009 After issuing address NUM_REG-1, COPY SHALL go to FLUSH, which writes address NUM_REG-1 with ckpt_rdata_i.
REQ-010 RESTORE SHALL last one cycle with pc_restore_o=1 and pc_o=ckpt_pc_i, then return to IDLE.
REQ-011 Total latency SHALL be:
- COPY at t+1..t+NUM_REG;
- FLUSH at t+NUM_REG+1;
- RESTORE at t+NUM_REG+2;
- IDLE at t+NUM_REG+3.
REQ-012 halt_o and busy_o SHALL be 1 in COPY, FLUSH and RESTORE.
REQ-013 In any non-IDLE state, core write inputs SHALL be ignored and never reach the rf write port.
REQ-014 error_i=1 in COPY, FLUSH or RESTORE SHALL restart COPY at address 0 on the next cycle, with no rf write that cycle, pc_restore_o forced to 0, and err_count_o incremented.
REQ-015 err_count_o SHALL saturate at 2**CNT_WIDTH-1 and never wrap.
REQ-016 Outside RESTORE, pc_restore_o SHALL be 0 and pc_o SHALL be 0.
REQ-017 Outside COPY, ckpt_raddr_o SHALL be 0.

Reset
REQ-018 rst=1 SHALL take priority over error_i, forcing IDLE, counter 0 and err_count_o 0.
REQ-019 After reset, halt_o=0, busy_o=0, pc_restore_o=0 and rf_we_o follows core_we_i.
REQ-020 rst asserted mid-recovery SHALL abort the sequence with no further rf writes and no pc_restore_o pulse.

Structure
REQ-021 Package recovery_pkg SHALL hold the state enum typedef and the default ADDR_WIDTH/DATA_WIDTH constants.
REQ-022 A single sub-module, sat_counter (parameter WIDTH, inputs clk/rst/inc, output count), SHALL implement err_count_o.

Verification
REQ-023 Single error: error_i pulse at cycle 10 (defaults) -> writes addr 0..31 at cycles 12..43, pc_restore_o at 44 with pc_o=ckpt_pc_i, halt_o=0 at 45, err_count_o=1.
REQ-024 Passthrough: in IDLE, core_we_i=1, addr 7, data 0xDEADBEEF -> same values on the rf port in the same cycle.
REQ-025 Error mid-COPY: second error while counter=15 -> next cycle ckpt_raddr_o=0, no rf write, full sequence reruns, err_count_o=2.
REQ-026 Core write blocked: core_we_i=1 during COPY -> no rf write carries core_waddr_i/core_wdata_i.
REQ-027 Reset mid-FLUSH: rst=1 -> next cycle IDLE, halt_o=0, err_count_o=0, no pc_restore_o pulse.
REQ-028 Saturation: CNT_WIDTH=2, with 5 errors -> err_count_o reaches 3 and stays 3.

Source files
------------

// File: rtl/recovery_pkg.sv
// Purpose : shared types and default widths for the lockstep recovery sequencer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package recovery_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COPY    = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_RESTORE = 2'd3
  } rec_state_e;

endpackage

// File: rtl/sat_counter.sv
// Purpose : event counter that sticks at its maximum value instead of wrapping.
// Latency : count updates on the edge after inc is seen.
// Backpressure: none; inc is ignored once saturated.
// Ports   : clk, rst (sync, active-high), inc (count one event), count (current value).
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/recovery_sequencer.sv
// Purpose : on a lockstep error, halt the core, copy the checkpoint bank into the rf, then reload the PC.
// Latency : error at edge t -> COPY t+1..t+NUM_REG, FLUSH t+NUM_REG+1, RESTORE t+NUM_REG+2, IDLE t+NUM_REG+3.
// Backpressure: none; core writes are dropped while busy, a new error restarts the copy from address 0.
// Ports   : clk/rst; error_i; core_we/waddr/wdata_i (normal writes); ckpt_raddr_o/ckpt_rdata_i/ckpt_pc_i
//           (checkpoint bank, 1-cycle read); rf_we/waddr/wdata_o; halt_o, busy_o, pc_restore_o, pc_o, err_count_o.
module recovery_sequencer
  import recovery_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  error_i,
  input  logic                  core_we_i,
  input  logic [ADDR_WIDTH-1:0] core_waddr_i,
  input  logic [DATA_WIDTH-1:0] core_wdata_i,
  output logic [ADDR_WIDTH-1:0] ckpt_raddr_o,
  input  logic [DATA_WIDTH-1:0] ckpt_rdata_i,
  input  logic [31:0]           ckpt_pc_i,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  halt_o,
  output logic                  busy_o,
  output logic                  pc_restore_o,
  output logic [31:0]           pc_o,
  output logic [CNT_WIDTH-1:0]  err_count_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  rec_state_e            r_state;
  rec_state_e            w_next_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_next_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    ckpt_raddr_o = '0;
    rf_we_o      = 1'b0;
    rf_waddr_o   = '0;
    rf_wdata_o   = '0;
    halt_o       = 1'b0;
    busy_o       = 1'b0;
    pc_restore_o = 1'b0;
    pc_o         = '0;

    case (r_state)
      ST_IDLE: begin
        rf_we_o    = core_we_i;
        rf_waddr_o = core_waddr_i;
        rf_wdata_o = core_wdata_i;
      end
      ST_COPY: begin
        halt_o       = 1'b1;
        busy_o       = 1'b1;
        ckpt_raddr_o = r_cnt;
        // Read data lags the address by one cycle, so the write trails the
        // read pointer by one. Counter is 0 only in the first COPY cycle,
        // when no read data is available yet.
        rf_we_o      = (r_cnt != '0);
        rf_waddr_o   = r_cnt - 1'b1;
        rf_wdata_o   = ckpt_rdata_i;
        w_next_cnt   = r_cnt + 1'b1;
        if (r_cnt == LAST_ADDR) begin
          w_next_state = ST_FLUSH;
          w_next_cnt   = '0;
        end
      end
      ST_FLUSH: begin
        halt_o       = 1'b1;
        busy_o       = 1'b1;
        rf_we_o      = 1'b1;
        rf_waddr_o   = LAST_ADDR;
        rf_wdata_o   = ckpt_rdata_i;
        w_next_state = ST_RESTORE;
      end
      ST_RESTORE: begin
        halt_o       = 1'b1;
        busy_o       = 1'b1;
        pc_restore_o = 1'b1;
        pc_o         = ckpt_pc_i;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    if (error_i) begin
      w_next_state = ST_COPY;
      w_next_cnt   = '0;
    end

    // A restart or reset during recovery cancels whatever the sequence was
    // about to commit this cycle, so a half-restored state is never exposed.
    if ((r_state != ST_IDLE) && (error_i || rst)) begin
      rf_we_o      = 1'b0;
      pc_restore_o = 1'b0;
    end
  end

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (error_i),
    .count(err_count_o)
  );

endmodule

// File: tb/tb_recovery_sequencer.sv
module tb_recovery_sequencer;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        error_i = 1'b0;
  logic        core_we = 1'b0;
  logic [4:0]  core_waddr = '0;
  logic [31:0] core_wdata = '0;
  logic [31:0] ckpt_rdata = '0;
  logic [31:0] ckpt_pc = '0;

  logic [4:0]  ckpt_raddr, rf_waddr, s_ckpt_raddr, s_rf_waddr;
  logic        rf_we, halt, busy, pc_restore, s_rf_we, s_halt, s_busy, s_pc_restore;
  logic [31:0] rf_wdata, pc_o, s_rf_wdata, s_pc_o;
  logic [7:0]  err_count;
  logic [1:0]  err_count_s;

  always #5 clk = ~clk;

  recovery_sequencer dut (
    .clk(clk), .rst(rst), .error_i(error_i),
    .core_we_i(core_we), .core_waddr_i(core_waddr), .core_wdata_i(core_wdata),
    .ckpt_raddr_o(ckpt_raddr), .ckpt_rdata_i(ckpt_rdata), .ckpt_pc_i(ckpt_pc),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .halt_o(halt), .busy_o(busy), .pc_restore_o(pc_restore), .pc_o(pc_o),
    .err_count_o(err_count)
  );

  recovery_sequencer #(.CNT_WIDTH(2)) dut_s (
    .clk(clk), .rst(rst), .error_i(error_i),
    .core_we_i(core_we), .core_waddr_i(core_waddr), .core_wdata_i(core_wdata),
    .ckpt_raddr_o(s_ckpt_raddr), .ckpt_rdata_i(ckpt_rdata), .ckpt_pc_i(ckpt_pc),
    .rf_we_o(s_rf_we), .rf_waddr_o(s_rf_waddr), .rf_wdata_o(s_rf_wdata),
    .halt_o(s_halt), .busy_o(s_busy), .pc_restore_o(s_pc_restore), .pc_o(s_pc_o),
    .err_count_o(err_count_s)
  );

  // Checkpoint bank contents; bit 31 kept clear so core data tagged with
  // bit 31 set can never be mistaken for a legitimate restore write.
  logic [31:0] bank [N];

  // Reference model: k = cycles since the current recovery began (0 = idle).
  int k = 0;
  int m_cnt = 0;
  int m_cnt_s = 0;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;

  logic [165:0] obs_vec, exp_vec;
  logic         o_we, o_halt, o_pcr;
  logic [4:0]   o_waddr, o_raddr;
  logic [31:0]  o_wdata, o_pc;
  logic [7:0]   o_cnt;
  logic [1:0]   o_cnt_s;

  task automatic fill_bank();
    for (int i = 0; i < N; i++) bank[i] = $urandom() & 32'h7FFF_FFFF;
    ckpt_pc = $urandom();
  endtask

  // Drive one cycle of inputs, sample outputs and expectations at negedge,
  // then advance the model and the checkpoint memory past the posedge.
  task automatic step(input logic e, input logic cwe, input logic [4:0] ca,
                      input logic [31:0] cd, input logic r);
    logic [4:0]  raddr_cap;
    logic        x_we, x_halt, x_pcr;
    logic [4:0]  x_wa, x_ra;
    logic [31:0] x_wd, x_pc;
    logic [77:0] exp_core, obs_core, obs_core_s;
    error_i = e; core_we = cwe; core_waddr = ca; core_wdata = cd; rst = r;
    @(negedge clk);
    x_we = 1'b0; x_wa = '0; x_wd = '0; x_pcr = 1'b0; x_pc = '0; x_ra = '0;
    x_halt = (k != 0);
    if (k == 0) begin
      x_we = cwe; x_wa = ca; x_wd = cd;
    end else if (k <= N) begin
      x_ra = 5'(k - 1);
      if (k > 1) begin x_we = 1'b1; x_wa = 5'(k - 2); x_wd = bank[k - 2]; end
    end else if (k == N + 1) begin
      x_we = 1'b1; x_wa = 5'(N - 1); x_wd = bank[N - 1];
    end else begin
      x_pcr = 1'b1; x_pc = ckpt_pc;
    end
    if (k != 0 && (e || r)) begin x_we = 1'b0; x_pcr = 1'b0; end
    if (!x_we) begin x_wa = '0; x_wd = '0; end
    exp_core   = {x_we, x_wa, x_wd, x_halt, x_halt, x_pcr, x_pc, x_ra};
    obs_core   = {rf_we, rf_we ? rf_waddr : 5'd0, rf_we ? rf_wdata : 32'd0,
                  halt, busy, pc_restore, pc_o, ckpt_raddr};
    obs_core_s = {s_rf_we, s_rf_we ? s_rf_waddr : 5'd0, s_rf_we ? s_rf_wdata : 32'd0,
                  s_halt, s_busy, s_pc_restore, s_pc_o, s_ckpt_raddr};
    exp_vec = {exp_core, exp_core, 8'(m_cnt), 2'(m_cnt_s)};
    obs_vec = {obs_core, obs_core_s, err_count, err_count_s};
    o_we = rf_we; o_waddr = rf_waddr; o_wdata = rf_wdata; o_halt = halt;
    o_pcr = pc_restore; o_pc = pc_o; o_raddr = ckpt_raddr;
    o_cnt = err_count; o_cnt_s = err_count_s;
    raddr_cap = ckpt_raddr;
    @(posedge clk);
    if (r) begin
      k = 0; m_cnt = 0; m_cnt_s = 0;
    end else if (e) begin
      k = 1;
      if (m_cnt < 255) m_cnt++;
      if (m_cnt_s < 3) m_cnt_s++;
    end else if (k != 0) begin
      k = (k == N + 2) ? 0 : k + 1;
    end
    cyc++;
    #1 ckpt_rdata = bank[raddr_cap];
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    // Error asserted together with reset must not count.
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
    n_cmp++;
    if (obs_vec !== exp_vec) begin
      n_mis++; $display("FAIL reset_hold cyc=%0d obs=%h exp=%h", cyc, obs_vec, exp_vec);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 5'($urandom()), $urandom(), 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_mis++; $display("FAIL reset_after cyc=%0d obs=%h exp=%h", cyc, obs_vec, exp_vec);
      end
    end
    n_cmp++;
    if (o_halt !== 1'b0 || o_cnt !== 8'd0 || o_pcr !== 1'b0) begin
      n_mis++; $display("FAIL reset_state halt=%b cnt=%0d pcr=%b want 0/0/0", o_halt, o_cnt, o_pcr);
    end
  endtask

  task automatic test_passthrough();
    step(1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0);
    n_cmp++;
    if (o_we !== 1'b1 || o_waddr !== 5'd7 || o_wdata !== 32'hDEADBEEF) begin
      n_mis++; $display("FAIL passthrough we=%b addr=%0d data=%h want 1/7/deadbeef", o_we, o_waddr, o_wdata);
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 5'($urandom()), $urandom(), 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_mis++; $display("FAIL passthrough_rand cyc=%0d obs=%h exp=%h", cyc, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_single_error();
    int first_wr = -1, last_wr = -1, n_wr = 0, rest_cyc = -1, halt45 = -1;
    logic [31:0] pc_seen = '0;
    fill_bank();
    do_reset();
    for (int c = 0; c < 50; c++) begin
      step(1'(c == 10), 1'($urandom_range(0, 1)), 5'($urandom()), 32'h8000_0000 | $urandom(), 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_mis++; $display("FAIL single_err cyc=%0d obs=%h exp=%h", c, obs_vec, exp_vec);
      end
      if (o_halt === 1'b1 && o_we === 1'b1) begin
        if (first_wr < 0) first_wr = c;
        last_wr = c; n_wr++;
      end
      if (o_pcr === 1'b1) begin rest_cyc = c; pc_seen = o_pc; end
      if (c == 45) halt45 = int'(o_halt);
    end
    n_cmp++;
    if (first_wr != 12 || last_wr != 43 || n_wr != 32) begin
      n_mis++; $display("FAIL single_err_writes first=%0d last=%0d n=%0d want 12/43/32", first_wr, last_wr, n_wr);
    end
    n_cmp++;
    if (rest_cyc != 44 || pc_seen !== ckpt_pc || halt45 != 0) begin
      n_mis++; $display("FAIL single_err_restore cyc=%0d pc=%h halt45=%0d want 44/%h/0", rest_cyc, pc_seen, halt45, ckpt_pc);
    end
    n_cmp++;
    if (o_cnt !== 8'd1) begin
      n_mis++; $display("FAIL single_err_count got=%0d want 1", o_cnt);
    end
  endtask

  task automatic test_error_mid_copy();
    fill_bank();
    do_reset();
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < 40 && k != 16; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    n_cmp++;
    if (k != 16) begin
      n_mis++; $display("FAIL mid_copy_reach k=%0d want 16", k);
    end
    step(1'b1, 1'b1, 5'd3, 32'h8000_1234, 1'b0);
    n_cmp++;
    if (obs_vec !== exp_vec || o_raddr !== 5'd15 || o_we !== 1'b0) begin
      n_mis++; $display("FAIL mid_copy_err cyc=%0d raddr=%0d we=%b want 15/0", cyc, o_raddr, o_we);
    end
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    n_cmp++;
    if (o_raddr !== 5'd0 || o_we !== 1'b0 || o_halt !== 1'b1) begin
      n_mis++; $display("FAIL mid_copy_restart raddr=%0d we=%b halt=%b want 0/0/1", o_raddr, o_we, o_halt);
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 5'($urandom()), 32'h8000_0000 | $urandom(), 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_mis++; $display("FAIL mid_copy_rerun cyc=%0d obs=%h exp=%h", cyc, obs_vec, exp_vec);
      end
    end
    n_cmp++;
    if (o_cnt !== 8'd2 || o_halt !== 1'b0) begin
      n_mis++; $display("FAIL mid_copy_final cnt=%0d halt=%b want 2/0", o_cnt, o_halt);
    end
  endtask

  task automatic test_core_blocked();
    logic [4:0]  ca;
    logic [31:0] cd;
    fill_bank();
    do_reset();
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < 36; i++) begin
      ca = 5'($urandom()); cd = 32'hC0DE_0000 | ($urandom() & 32'hFFFF);
      step(1'b0, 1'b1, ca, cd, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_mis++; $display("FAIL core_blocked cyc=%0d obs=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      n_cmp++;
      if (o_halt === 1'b1 && o_we === 1'b1 && o_waddr === ca && o_wdata === cd) begin
        n_mis++; $display("FAIL core_leak cyc=%0d addr=%0d data=%h want no core write", cyc, o_waddr, o_wdata);
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    fill_bank();
    do_reset();
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < 40 && k != N + 1; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    n_cmp++;
    if (obs_vec !== exp_vec || o_we !== 1'b0) begin
      n_mis++; $display("FAIL flush_reset cyc=%0d we=%b obs=%h exp=%h", cyc, o_we, obs_vec, exp_vec);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      n_cmp++;
      if (o_halt !== 1'b0 || o_cnt !== 8'd0 || o_pcr !== 1'b0 || obs_vec !== exp_vec) begin
        n_mis++; $display("FAIL flush_after cyc=%0d halt=%b cnt=%0d pcr=%b want 0/0/0", cyc, o_halt, o_cnt, o_pcr);
      end
    end
  endtask

  task automatic test_saturation();
    fill_bank();
    do_reset();
    for (int j = 0; j < 5; j++) begin
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      for (int i = 0; i < 2; i++) begin
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        n_cmp++;
        if (obs_vec !== exp_vec) begin
          n_mis++; $display("FAIL saturation cyc=%0d obs=%h exp=%h", cyc, obs_vec, exp_vec);
        end
      end
    end
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    n_cmp++;
    if (o_cnt_s !== 2'd3 || o_cnt !== 8'd5) begin
      n_mis++; $display("FAIL saturation_final cnt_s=%0d cnt=%0d want 3/5", o_cnt_s, o_cnt);
    end
  endtask

  task automatic test_random();
    fill_bank();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 5'($urandom()),
           $urandom(), 1'($urandom_range(0, 299) == 0));
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_mis++; $display("FAIL random cyc=%0d obs=%h exp=%h", cyc, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    fill_bank();
    test_reset();
    test_passthrough();
    test_single_error();
    test_error_mid_copy();
    test_core_blocked();
    test_reset_mid_flush();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
